// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default datapath width, the NOP encoding the
// decode stage sees when nothing is buffered, and the fetch packet layout.
package pipeline_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // One fetched instruction together with its PC, as produced by fetch.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pkt_t;

    localparam int FETCH_PKT_W = $bits(fetch_pkt_t);

endpackage

// File: rtl/if_id_buffer_mem.sv
// Storage array for the IF/ID buffer: one synchronous write port and one
// combinational read port. Contents are deliberately not reset; validity
// is tracked by the occupancy count in the top.
module if_id_buffer_mem #(
    parameter int DEPTH = 4,
    parameter int DW    = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Write the entry addressed by the write pointer on an accepted push.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID decoupling buffer. Holds {PC, instruction} pairs from fetch and
// hands them to decode with a valid/ready handshake; a taken branch (flush)
// drops every buffered wrong-path entry in one cycle.
// Optional statistics counters are enabled by defining IF_ID_BUFFER_STATS_EN.
module if_id_buffer
    import pipeline_pkg::*;
#(
    parameter int               WIDTH     = XLEN,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_pc,
    input  logic [WIDTH-1:0]         in_instr,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_pc,
    output logic [WIDTH-1:0]         out_instr,
    input  logic                     out_ready,
`ifdef IF_ID_BUFFER_STATS_EN
    output logic [31:0]              stall_cycles,
    output logic [31:0]              flushed_instrs,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 push, pop, we;
    logic [2*WIDTH-1:0]   rd_data;

    // Full/empty come from the count, never from pointer comparison.
    // in_ready is held high during flush since fetch redirects that cycle.
    assign in_ready  = (count_q != CW'(DEPTH)) | flush;
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign we        = push & ~rst;

    // Outputs gated by out_valid so stale or uninitialised storage never leaks.
    assign out_pc    = out_valid ? rd_data[2*WIDTH-1:WIDTH] : '0;
    assign out_instr = out_valid ? rd_data[WIDTH-1:0]       : NOP_INSTR;
    assign count     = count_q;

    if_id_buffer_mem #(
        .DEPTH (DEPTH),
        .DW    (2*WIDTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i ({in_pc, in_instr}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    // Next-state for pointers and occupancy; flush overrides push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef IF_ID_BUFFER_STATS_EN
    logic [31:0] stall_q, flushed_q;
    logic [32:0] flushed_sum;

    assign flushed_sum    = {1'b0, flushed_q} + 33'(count_q);
    assign stall_cycles   = stall_q;
    assign flushed_instrs = flushed_q;

    // Saturating statistics; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q   <= '0;
            flushed_q <= '0;
        end else begin
            if (in_valid && !in_ready && stall_q != '1) begin
                stall_q <= stall_q + 32'd1;
            end
            if (flush) begin
                flushed_q <= flushed_sum[32] ? '1 : flushed_sum[31:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed self-checking bench for if_id_buffer (DEPTH=4, WIDTH=32).
module tb_if_id_buffer;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_pc, in_instr;
    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_instr;
    logic [2:0]  count;
`ifdef IF_ID_BUFFER_STATS_EN
    logic [31:0] stall_cycles, flushed_instrs;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    if_id_buffer #(.WIDTH(32), .DEPTH(4), .NOP_INSTR(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_pc          (in_pc),
        .in_instr       (in_instr),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_ready      (out_ready),
`ifdef IF_ID_BUFFER_STATS_EN
        .stall_cycles   (stall_cycles),
        .flushed_instrs (flushed_instrs),
`endif
        .count          (count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins, input logic rdy);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = rdy;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);

        // Reset then idle
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_count",  32'(count),     32'd0);
        chk("rst_ovalid", 32'(out_valid), 32'd0);
        chk("rst_oinstr", out_instr,      32'h0);
        chk("rst_opc",    out_pc,         32'h0);
        chk("rst_irdy",   32'(in_ready),  32'd1);

        // Fill without drain, then a refused fifth push
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4*i), 32'hA0 + 32'(i), 1'b0);
            tick();
        end
        chk("fill_count", 32'(count),    32'd4);
        chk("fill_irdy",  32'(in_ready), 32'd0);
        chk("fill_pc",    out_pc,        32'h0);
        chk("fill_instr", out_instr,     32'hA0);
        drive(1'b1, 32'd16, 32'hA4, 1'b0);
        tick();
        chk("fill5_count", 32'(count), 32'd4);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc",    out_pc,    32'(4*i));
            chk("drain_instr", out_instr, 32'hA0 + 32'(i));
            tick();
        end
        chk("drain_empty", 32'(out_valid), 32'd0);
        chk("drain_nop",   out_instr,      32'h0);

        // Streaming with continuous push and pop
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 32'(4*k), 32'hC0 + 32'(k), 1'b1);
            tick();
            chk("strm_valid", 32'(out_valid), 32'd1);
            chk("strm_pc",    out_pc,         32'(4*k));
            chk("strm_count", 32'(count),     32'd1);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        chk("strm_end", 32'(count), 32'd0);

        // Full + pop: pop only, push lands next cycle
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h200 + 32'(4*i), 32'hD0 + 32'(i), 1'b0);
            tick();
        end
        drive(1'b1, 32'h300, 32'hE0, 1'b1);
        tick();
        chk("fp_count3", 32'(count), 32'd3);
        chk("fp_head",   out_pc,     32'h204);
        drive(1'b1, 32'h300, 32'hE0, 1'b0);
        tick();
        chk("fp_count4", 32'(count),    32'd4);
        chk("fp_irdy",   32'(in_ready), 32'd0);
        drive(1'b1, 32'h304, 32'hE1, 1'b0);
        tick();
        chk("fp_hold", 32'(count), 32'd4);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        chk("fp_d0", out_pc, 32'h204); tick();
        chk("fp_d1", out_pc, 32'h208); tick();
        chk("fp_d2", out_pc, 32'h20C); tick();
        chk("fp_d3", out_pc, 32'h300); chk("fp_d3i", out_instr, 32'hE0); tick();
        chk("fp_empty", 32'(count), 32'd0);

        // Flush with a same-cycle push and pop
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h10 + 32'(4*i), 32'hF0 + 32'(i), 1'b0);
            tick();
        end
        chk("fl_pre", 32'(count), 32'd3);
        flush = 1'b1;
        drive(1'b1, 32'd40, 32'hBAD, 1'b1);
        #1;
        chk("fl_irdy", 32'(in_ready), 32'd1);
        tick();
        flush = 1'b0;
        chk("fl_count",  32'(count),     32'd0);
        chk("fl_ovalid", 32'(out_valid), 32'd0);
        chk("fl_opc",    out_pc,         32'h0);
`ifdef IF_ID_BUFFER_STATS_EN
        chk("fl_stat", flushed_instrs, 32'd3);
`endif
        drive(1'b1, 32'h100, 32'hB0, 1'b0);
        tick();
        chk("fl_nvalid", 32'(out_valid), 32'd1);
        chk("fl_npc",    out_pc,         32'h100);
        chk("fl_ninstr", out_instr,      32'hB0);
        chk("fl_ncount", 32'(count),     32'd1);

        // Reset mid-operation
        drive(1'b1, 32'h104, 32'hB1, 1'b0);
        tick();
        chk("mr_pre", 32'(count), 32'd2);
`ifdef IF_ID_BUFFER_STATS_EN
        chk("mr_stall_pre", stall_cycles, 32'd3);
`endif
        rst = 1'b1;
        drive(1'b1, 32'h108, 32'hB2, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        chk("mr_count",  32'(count),     32'd0);
        chk("mr_ovalid", 32'(out_valid), 32'd0);
        chk("mr_opc",    out_pc,         32'h0);
        chk("mr_oinstr", out_instr,      32'h0);
        chk("mr_irdy",   32'(in_ready),  32'd1);
`ifdef IF_ID_BUFFER_STATS_EN
        chk("mr_stall", stall_cycles,   32'd0);
        chk("mr_flshd", flushed_instrs, 32'd0);
`endif
        tick();
        chk("mr_idle", 32'(count), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
